// File: rtl/led_pwm_breathe_if.sv
// Signal bundle between the blink generator / board logic and the breathing
// LED stage. The controller drives enable and toggle. The LED stage drives
// the PWM pin, the current brightness and the fade-in-progress flag.
interface led_pwm_breathe_if #(
  parameter int unsigned PWM_BITS = 4
);
  logic                enable;
  logic                toggle;
  logic                led;
  logic [PWM_BITS-1:0] level;
  logic                busy;

  modport master (output enable, output toggle,
                  input  led,    input  level,  input busy);
  modport slave  (input  enable, input  toggle,
                  output led,    output level,  output busy);
endinterface

// File: rtl/led_pwm_breathe.sv
// Breathing LED driver. Each edge of the blink toggle starts a smooth PWM
// fade in the matching direction. Brightness moves one step every STEP_DIV
// completed PWM periods, and only ever at a period boundary.
// Optional build macro LED_PWM_BREATHE_GAMMA_EN selects a square-law
// brightness-to-duty curve. That curve adds one cycle of led latency.
module led_pwm_breathe #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned STEP_DIV = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  led_pwm_breathe_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [PWM_BITS-1:0] LVL_MAX_1 = LVL_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [15:0]         STEP_LAST = 16'(STEP_DIV - 1);

  typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;

  state_t              state_q;
  logic                tog_s1_q, tog_s2_q, tog_prev_q;
  logic                rise, fall;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [15:0]         step_cnt_q;
  logic                wrap, step;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] duty;
  logic                led_q;
  logic                busy_q;

  assign rise = tog_s2_q & ~tog_prev_q;
  assign fall = ~tog_s2_q & tog_prev_q;
  assign wrap = &pwm_cnt_q;
  assign step = wrap && (step_cnt_q == STEP_LAST);

  // Synchronise toggle. Keep tracking it while disabled, so that
  // re-enabling never replays a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_s1_q   <= 1'b0;
      tog_s2_q   <= 1'b0;
      tog_prev_q <= 1'b0;
    end else begin
      tog_s1_q   <= bus.toggle;
      tog_s2_q   <= tog_s1_q;
      tog_prev_q <= tog_s2_q;
    end
  end

  // Free-running PWM period counter. It keeps running while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + 1'b1;
  end

  // Count completed PWM periods. The count clears on each brightness step
  // and whenever the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       step_cnt_q <= '0;
    else if (!bus.enable) step_cnt_q <= '0;
    else if (step)    step_cnt_q <= '0;
    else if (wrap)    step_cnt_q <= step_cnt_q + 16'd1;
  end

`ifdef LED_PWM_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] lvl_wide;
  logic [2*PWM_BITS-1:0] lvl_sq;
  logic [PWM_BITS-1:0]   duty_q;

  assign lvl_wide = {{PWM_BITS{1'b0}}, level_q};
  assign lvl_sq   = lvl_wide * lvl_wide;

  // Register the square-law duty, so the multiplier stays out of the
  // compare path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           duty_q <= '0;
    else if (!bus.enable) duty_q <= '0;
    else                  duty_q <= lvl_sq[2*PWM_BITS-1:PWM_BITS];
  end
  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  // PWM compare. The output is registered, so the pin is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= 1'b0;
    else        led_q <= bus.enable & (pwm_cnt_q < duty);
  end

  // Fade state machine. An edge wins over a simultaneous step. The range
  // checks on each step also saturate a fade that reversed before it moved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else if (!bus.enable) begin
      state_q <= OFF;
      level_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        OFF: begin
          if (rise) begin
            state_q <= RISE;
            busy_q  <= 1'b1;
          end
        end
        RISE: begin
          if (fall) begin
            state_q <= FALL;
            busy_q  <= 1'b1;
          end else if (step) begin
            if (level_q >= LVL_MAX_1) begin
              level_q <= LVL_MAX;
              state_q <= ON;
              busy_q  <= 1'b0;
            end else begin
              level_q <= level_q + 1'b1;
            end
          end
        end
        ON: begin
          if (fall) begin
            state_q <= FALL;
            busy_q  <= 1'b1;
          end
        end
        FALL: begin
          if (rise) begin
            state_q <= RISE;
            busy_q  <= 1'b1;
          end else if (step) begin
            if (level_q <= LVL_ONE) begin
              level_q <= '0;
              state_q <= OFF;
              busy_q  <= 1'b0;
            end else begin
              level_q <= level_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= OFF;
          level_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led   = led_q;
  assign bus.level = level_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_pwm_breathe.sv
// Bench for the breathing LED stage with PWM_BITS=4 and STEP_DIV=2, so one
// brightness step lands every 32 cycles after reset release.
module tb_led_pwm_breathe;

  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_pwm_breathe_if #(.PWM_BITS(PW)) bus ();

  led_pwm_breathe #(.PWM_BITS(PW), .STEP_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int unsigned cyc;

  // Count cycles since reset release. Brightness steps fall on multiples of 32.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    logic tog;
    int   lvl;
    logic busy;
    int   duty_lvl;
  } vec_t;

  typedef struct {
    string name;
    int    lvl;
    logic  busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int duty_of(input int l);
`ifdef LED_PWM_BREATHE_GAMMA_EN
    return (l * l) >> PW;
`else
    return l;
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level_change(input string name);
    logic [PW-1:0] prev;
    bit ok;
    prev = bus.level;
    ok   = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (bus.level != prev) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        seen = 1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  task automatic count_led(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt += int'(bus.led);
    end
  endtask

  task automatic count_active(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.led || bus.busy || bus.level != '0) cnt++;
    end
  endtask

  function automatic void add(input logic t, input int l, input logic b, input int d);
    vec_t v;
    v.tog = t; v.lvl = l; v.busy = b; v.duty_lvl = d;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   lat;
    exp_t e;

    // Full rise, full fall, reverse at 6, reverse again at 5, then fall at 10.
    for (int i = 1; i <= 15; i++) add(1'b1, i, (i < 15), (i == 15) ? 15 : -1);
    for (int i = 14; i >= 0; i--) add(1'b0, i, (i > 0), (i == 0) ? 0 : -1);
    for (int i = 1; i <= 6; i++)  add(1'b1, i, 1'b1, (i == 6) ? 6 : -1);
    add(1'b0, 5, 1'b1, -1);
    for (int i = 6; i <= 10; i++) add(1'b1, i, 1'b1, -1);
    add(1'b0, 9, 1'b1, -1);

    bus.enable = 1'b1;
    bus.toggle = 1'b0;
    rst_n      = 1'b0;
    cycles(3);
    check("reset_led",   int'(bus.led),   0);
    check("reset_level", int'(bus.level), 0);
    check("reset_busy",  int'(bus.busy),  0);
    rst_n = 1'b1;

    count_active(200, cnt);
    check("idle_quiet", cnt, 0);

    // Rising edge to busy: two synchroniser flops plus the edge register
    // and FSM register, counted from the cycle the toggle was driven.
    bus.toggle = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.busy && lat == 0) lat = i;
    end
    n_checks++;
    if (!(lat inside {3, 4})) begin
      n_err++;
      $display("FAIL rise_latency: got %0d expected 3..4", lat);
    end

    foreach (vecs[k]) begin
      exp_t x;
      bus.toggle = vecs[k].tog;
      x.name = $sformatf("row%0d", k);
      x.lvl  = vecs[k].lvl;
      x.busy = vecs[k].busy;
      sbq.push_back(x);
      wait_level_change(x.name);
      e = sbq.pop_front();
      check({e.name, "_level"}, int'(bus.level), e.lvl);
      check({e.name, "_busy"},  int'(bus.busy),  int'(e.busy));
      check({e.name, "_phase"}, int'(cyc % 32),  0);
      if (vecs[k].duty_lvl >= 0) begin
        cycles(2);
        count_led(16, cnt);
        check({e.name, "_duty"}, cnt, duty_of(vecs[k].duty_lvl));
      end
    end

    // Asynchronous reset in the middle of a fall.
    cycles(5);
    rst_n = 1'b0;
    #1;
    check("async_rst_led",   int'(bus.led),   0);
    check("async_rst_level", int'(bus.level), 0);
    check("async_rst_busy",  int'(bus.busy),  0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_active(100, cnt);
    check("post_reset_off", cnt, 0);

    bus.toggle = 1'b1;
    wait_busy("post_reset_rise_busy");
    wait_level_change("post_reset_l1");
    check("post_reset_l1", int'(bus.level), 1);
    wait_level_change("post_reset_l2");
    check("post_reset_l2", int'(bus.level), 2);

    // Disable while rising.
    bus.enable = 1'b0;
    @(negedge clk);
    check("disable_level", int'(bus.level), 0);
    check("disable_led",   int'(bus.led),   0);
    check("disable_busy",  int'(bus.busy),  0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      int c;
      bus.toggle = 1'b0;
      count_active(8, c);
      cnt += c;
      bus.toggle = 1'b1;
      count_active(8, c);
      cnt += c;
    end
    check("disabled_pulses_ignored", cnt, 0);

    bus.enable = 1'b1;
    count_active(100, cnt);
    check("reenable_stays_off", cnt, 0);

    bus.toggle = 1'b0;
    count_active(12, cnt);
    check("fall_in_off_ignored", cnt, 0);

    bus.toggle = 1'b1;
    wait_busy("reenable_rise_busy");
    wait_level_change("reenable_l1");
    check("reenable_l1", int'(bus.level), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
